// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator fed by two line buffers; one window per interior pixel, 1-cycle latency.
// Backpressure: input is held off whenever a window is waiting and win_ready is low, so no pixel is dropped.
module sobel_window_gen #(
    parameter int PIXEL_WIDTH = 8,
    parameter int MAX_WIDTH   = 256,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic                     abort_i,
    input  logic [CNT_WIDTH-1:0]     width_i,
    input  logic [CNT_WIDTH-1:0]     height_i,
    input  logic                     pix_valid_i,
    output logic                     pix_ready_o,
    input  logic [PIXEL_WIDTH-1:0]   pix_data_i,
    output logic                     win_valid_o,
    input  logic                     win_ready_i,
    output logic [9*PIXEL_WIDTH-1:0] win_data_o,
    output logic [CNT_WIDTH-1:0]     win_x_o,
    output logic [CNT_WIDTH-1:0]     win_y_o,
    output logic                     frame_done_o,
    output logic                     cfg_err_o
);

    localparam int ADDR_WIDTH = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] TWO     = CNT_WIDTH'(2);
    localparam logic [CNT_WIDTH-1:0] MIN_DIM = CNT_WIDTH'(3);
    localparam logic [CNT_WIDTH-1:0] MAX_W   = CNT_WIDTH'(MAX_WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CNT_WIDTH-1:0]   width_q, height_q;
    logic [CNT_WIDTH-1:0]   x_q, y_q;
    logic [PIXEL_WIDTH-1:0] lb_a [MAX_WIDTH];
    logic [PIXEL_WIDTH-1:0] lb_b [MAX_WIDTH];
    logic [PIXEL_WIDTH-1:0] win_q [9];
    logic [ADDR_WIDTH-1:0]  lb_addr;

    logic cfg_ok;
    logic start_ok;
    logic pix_accept;
    logic pix_step;
    logic last_col;
    logic last_pix;
    logic win_emit;
    logic win_pending;

    assign cfg_ok      = (width_i >= MIN_DIM) && (width_i <= MAX_W) && (height_i >= MIN_DIM);
    assign start_ok    = (state_q == IDLE) && start_i && cfg_ok && !abort_i;
    assign pix_accept  = pix_valid_i && pix_ready_o;
    assign pix_step    = pix_accept && !abort_i;
    assign last_col    = (x_q == width_q - ONE);
    assign last_pix    = last_col && (y_q == height_q - ONE);
    assign win_emit    = pix_step && (x_q >= TWO) && (y_q >= TWO);
    assign win_pending = win_valid_o && !win_ready_i;
    assign lb_addr     = x_q[ADDR_WIDTH-1:0];

    // FSM: state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (start_ok) state_d = RUN;
                RUN:     if (pix_step && last_pix) state_d = FLUSH;
                FLUSH:   if (!win_pending) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM: outputs; a consume and a new pixel may coincide for full throughput
    always_comb begin
        pix_ready_o = (state_q == RUN) && (!win_valid_o || win_ready_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            width_q  <= '0;
            height_q <= '0;
            x_q      <= '0;
            y_q      <= '0;
        end else if (abort_i) begin
            x_q <= '0;
            y_q <= '0;
        end else if (start_ok) begin
            width_q  <= width_i;
            height_q <= height_i;
            x_q      <= '0;
            y_q      <= '0;
        end else if (pix_step) begin
            if (last_col) begin
                x_q <= '0;
                y_q <= y_q + ONE;
            end else begin
                x_q <= x_q + ONE;
            end
        end
    end

    // Line buffers hold the two previous rows; contents need no reset
    always_ff @(posedge clk_i) begin
        if (pix_step) begin
            lb_a[lb_addr] <= lb_b[lb_addr];
            lb_b[lb_addr] <= pix_data_i;
        end
    end

    // Window shifts only on accepted pixels, so it stays frozen while a window is held
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= '0;
            end
        end else if (pix_step) begin
            for (int r = 0; r < 3; r++) begin
                win_q[3*r]   <= win_q[3*r+1];
                win_q[3*r+1] <= win_q[3*r+2];
            end
            win_q[2] <= lb_a[lb_addr];
            win_q[5] <= lb_b[lb_addr];
            win_q[8] <= pix_data_i;
        end
    end

    always_comb begin
        win_data_o = '0;
        for (int i = 0; i < 9; i++) begin
            win_data_o[i*PIXEL_WIDTH +: PIXEL_WIDTH] = win_q[i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            win_valid_o  <= 1'b0;
            win_x_o      <= '0;
            win_y_o      <= '0;
            frame_done_o <= 1'b0;
            cfg_err_o    <= 1'b0;
        end else begin
            frame_done_o <= (state_q == FLUSH) && !win_pending && !abort_i;
            cfg_err_o    <= (state_q == IDLE) && start_i && !cfg_ok && !abort_i;
            if (abort_i) begin
                win_valid_o <= 1'b0;
            end else if (win_emit) begin
                win_valid_o <= 1'b1;
                win_x_o     <= x_q - ONE;
                win_y_o     <= y_q - ONE;
            end else if (win_ready_i) begin
                win_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen: drives on the falling edge, samples 2 time units later.
module tb_sobel_window_gen;

    localparam int PW = 8;
    localparam int MW = 256;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] width = '0;
    logic [CW-1:0] height = '0;
    logic          pix_valid = 1'b0;
    logic          pix_ready;
    logic [PW-1:0] pix_data = '0;
    logic          win_valid;
    logic          win_ready = 1'b0;
    logic [9*PW-1:0] win_data;
    logic [CW-1:0] win_x;
    logic [CW-1:0] win_y;
    logic          frame_done;
    logic          cfg_err;

    sobel_window_gen #(
        .PIXEL_WIDTH (PW),
        .MAX_WIDTH   (MW),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .abort_i      (abort),
        .width_i      (width),
        .height_i     (height),
        .pix_valid_i  (pix_valid),
        .pix_ready_o  (pix_ready),
        .pix_data_i   (pix_data),
        .win_valid_o  (win_valid),
        .win_ready_i  (win_ready),
        .win_data_o   (win_data),
        .win_x_o      (win_x),
        .win_y_o      (win_y),
        .frame_done_o (frame_done),
        .cfg_err_o    (cfg_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    logic [9*PW-1:0] got_data [$];
    logic [CW-1:0]   got_x [$];
    logic [CW-1:0]   got_y [$];

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // pattern 0: pixels numbered 1.. in raster order; pattern 1: 16*y + x
    function automatic logic [PW-1:0] pix_val(input int pat, input int w, input int x, input int y);
        if (pat == 0) return PW'(y * w + x + 1);
        return PW'(16 * y + x);
    endfunction

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
            if (frame_done) done_cnt++;
        end
    endtask

    // Starts a frame and feeds up to max_pix pixels; holds win_ready low for
    // 'stall' cycles once the first window appears. Returns on a falling edge.
    task automatic feed(input int w, input int h, input int pat, input int max_pix,
                        input int stall, input bit wait_done);
        int idx = 0;
        int stall_left = stall;
        int cyc = 0;
        bit fin = 0;
        logic [9*PW-1:0] held = '0;
        got_data.delete();
        got_x.delete();
        got_y.delete();
        done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        width = CW'(w);
        height = CW'(h);
        @(negedge clk);
        start = 1'b0;
        while (!fin && cyc < 2000) begin
            pix_valid = (idx < max_pix);
            pix_data = pix_val(pat, w, idx % w, idx / w);
            win_ready = !(stall_left > 0 && win_valid);
            #2;
            if (!win_ready) begin
                if (stall_left < stall) check("stall_data", win_data, held);
                else held = win_data;
                check("stall_pix_ready", 72'(pix_ready), 72'(0));
                stall_left--;
            end
            if (pix_valid && pix_ready) idx++;
            if (win_valid && win_ready) begin
                got_data.push_back(win_data);
                got_x.push_back(win_x);
                got_y.push_back(win_y);
            end
            if (frame_done) done_cnt++;
            fin = wait_done ? (done_cnt > 0) : (idx >= max_pix);
            cyc++;
            @(negedge clk);
        end
        pix_valid = 1'b0;
        if (!wait_done) check("pixels_fed", 72'(idx), 72'(max_pix));
    endtask

    task automatic check_windows(input int w, input int h, input int pat);
        int k = 0;
        logic [9*PW-1:0] e;
        check("win_count", 72'(got_data.size()), 72'((w - 2) * (h - 2)));
        for (int cy = 1; cy <= h - 2; cy++) begin
            for (int cx = 1; cx <= w - 2; cx++) begin
                e = '0;
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        e[(3*r+c)*PW +: PW] = pix_val(pat, w, cx - 1 + c, cy - 1 + r);
                if (k < got_data.size()) begin
                    check("win_data", got_data[k], e);
                    check("win_x", 72'(got_x[k]), 72'(cx));
                    check("win_y", 72'(got_y[k]), 72'(cy));
                end
                k++;
            end
        end
    endtask

    task automatic bad_cfg(input int w, input int h);
        @(negedge clk);
        start = 1'b1;
        width = CW'(w);
        height = CW'(h);
        pix_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #2;
        check("cfg_err_pulse", 72'(cfg_err), 72'(1));
        check("cfg_err_pix_ready", 72'(pix_ready), 72'(0));
        @(negedge clk);
        #2;
        check("cfg_err_clear", 72'(cfg_err), 72'(0));
        check("cfg_err_idle", 72'(pix_ready), 72'(0));
        pix_valid = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_win_valid"}, 72'(win_valid), 72'(0));
        check({tag, "_win_data"}, win_data, 72'(0));
        check({tag, "_win_xy"}, 72'({win_x, win_y}), 72'(0));
        check({tag, "_pix_ready"}, 72'(pix_ready), 72'(0));
        check({tag, "_pulses"}, 72'({frame_done, cfg_err}), 72'(0));
    endtask

    initial begin
        #12;
        check_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Smallest legal frame
        feed(3, 3, 0, 9, 0, 1);
        idle_cycles(3);
        check("done_3x3", 72'(done_cnt), 72'(1));
        check_windows(3, 3, 0);

        // 5x4 streaming at full throughput
        feed(5, 4, 1, 20, 0, 1);
        idle_cycles(3);
        check("done_5x4", 72'(done_cnt), 72'(1));
        check_windows(5, 4, 1);
        if (got_data.size() > 1) check("w21_slice4", 72'(got_data[1][39:32]), 72'(8'h12));

        // Same frame with a 10-cycle downstream stall on the first window
        feed(5, 4, 1, 20, 10, 1);
        idle_cycles(3);
        check("done_stall", 72'(done_cnt), 72'(1));
        check_windows(5, 4, 1);

        // Rejected configurations
        bad_cfg(2, 3);
        bad_cfg(MW + 1, 3);
        bad_cfg(5, 2);

        // Abort after 7 pixels, then a clean 3x3 frame
        feed(5, 4, 1, 7, 0, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        pix_valid = 1'b1;
        #2;
        check("abort_win_valid", 72'(win_valid), 72'(0));
        check("abort_idle", 72'(pix_ready), 72'(0));
        check("abort_no_done", 72'(frame_done), 72'(0));
        pix_valid = 1'b0;
        feed(3, 3, 0, 9, 0, 1);
        idle_cycles(2);
        check("done_after_abort", 72'(done_cnt), 72'(1));
        check_windows(3, 3, 0);

        // Reset with a window pending, then a clean 3x3 frame
        feed(5, 4, 1, 13, 0, 0);
        win_ready = 1'b0;
        #1;
        check("pre_reset_pending", 72'(win_valid), 72'(1));
        rst_n = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        feed(3, 3, 0, 9, 0, 1);
        idle_cycles(2);
        check("done_after_reset", 72'(done_cnt), 72'(1));
        check_windows(3, 3, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
